// File: rtl/ram_input_loader.sv
// Stream-to-RAM loader for the ODE solver: decodes the problem description
// stream and issues registered writes on the four solver RAM ports.
module ram_input_loader #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDRESS_WIDTH_1 = 10,
  parameter int ADDRESS_WIDTH_2 = 12,
  parameter int ADDRESS_WIDTH_3 = 12,
  parameter int ADDRESS_WIDTH_4 = 10,
  parameter int MAX_N           = 50,
  parameter int MAX_T           = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [ADDRESS_WIDTH_1-1:0] address_1,
  output logic [ADDRESS_WIDTH_2-1:0] address_2,
  output logic [ADDRESS_WIDTH_3-1:0] address_3,
  output logic [ADDRESS_WIDTH_4-1:0] address_4,
  output logic [DATA_WIDTH-1:0]      data_write_1,
  output logic [DATA_WIDTH-1:0]      data_write_2,
  output logic [DATA_WIDTH-1:0]      data_write_3,
  output logic [DATA_WIDTH-1:0]      data_write_4,
  output logic                       WR_signal_1,
  output logic                       WR_signal_2,
  output logic                       WR_signal_3,
  output logic                       WR_signal_4,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_N, S_HDR_M, S_HDR_K, S_HDR_H, S_HDR_ERR,
    S_LD_T, S_LD_A, S_LD_B, S_LD_X0, S_LD_U0, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  n_q, n_d, m_q, m_d;
  logic [4:0]  k_q, k_d;
  logic [11:0] nn_q, nn_d, nm_q, nm_d;
  logic [11:0] cnt_limit;
  logic        accept, last_elem, hi_nz, bad_n, bad_m, bad_k;
  logic [7:0]  lo;

  logic                       wr1_q, wr1_d, wr2_q, wr2_d, wr3_q, wr3_d, wr4_q, wr4_d;
  logic [ADDRESS_WIDTH_1-1:0] addr1_q, addr1_d;
  logic [ADDRESS_WIDTH_2-1:0] addr2_q, addr2_d;
  logic [ADDRESS_WIDTH_3-1:0] addr3_q, addr3_d;
  logic [ADDRESS_WIDTH_4-1:0] addr4_q, addr4_d;
  logic [DATA_WIDTH-1:0]      data1_q, data1_d, data2_q, data2_d;
  logic [DATA_WIDTH-1:0]      data3_q, data3_d, data4_q, data4_d;

  assign accept = data_valid & data_ready;
  assign hi_nz  = |data_in[DATA_WIDTH-1:8];
  assign lo     = data_in[7:0];
  assign bad_n  = hi_nz || (lo == 8'd0) || (lo > 8'(MAX_N));
  assign bad_m  = bad_n;
  assign bad_k  = hi_nz || (lo == 8'd0) || (lo > 8'(MAX_T));

  // Products track the latched N/M continuously; both settle long before LD_A.
  assign nn_d = {6'd0, n_q} * {6'd0, n_q};
  assign nm_d = {6'd0, n_q} * {6'd0, m_q};

  always_comb begin
    cnt_limit = 12'd1;
    case (state_q)
      S_LD_T:  cnt_limit = {7'd0, k_q};
      S_LD_A:  cnt_limit = nn_q;
      S_LD_B:  cnt_limit = nm_q;
      S_LD_X0: cnt_limit = {6'd0, n_q};
      S_LD_U0: cnt_limit = {6'd0, m_q};
      default: cnt_limit = 12'd1;
    endcase
  end
  assign last_elem = (cnt_q == cnt_limit - 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      nn_q    <= '0;
      nm_q    <= '0;
      wr1_q   <= 1'b0;
      wr2_q   <= 1'b0;
      wr3_q   <= 1'b0;
      wr4_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      addr3_q <= '0;
      addr4_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
      data3_q <= '0;
      data4_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      m_q     <= m_d;
      k_q     <= k_d;
      nn_q    <= nn_d;
      nm_q    <= nm_d;
      wr1_q   <= wr1_d;
      wr2_q   <= wr2_d;
      wr3_q   <= wr3_d;
      wr4_q   <= wr4_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      addr3_q <= addr3_d;
      addr4_q <= addr4_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      data3_q <= data3_d;
      data4_q <= data4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    m_d     = m_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_HDR_N;
      S_HDR_N:   if (accept) begin
                   state_d = bad_n ? S_ERR : S_HDR_M;
                   if (!bad_n) n_d = data_in[5:0];
                 end
      S_HDR_M:   if (accept) begin
                   state_d = bad_m ? S_ERR : S_HDR_K;
                   if (!bad_m) m_d = data_in[5:0];
                 end
      S_HDR_K:   if (accept) begin
                   state_d = bad_k ? S_ERR : S_HDR_H;
                   if (!bad_k) k_d = data_in[4:0];
                 end
      S_HDR_H:   if (accept) state_d = S_HDR_ERR;
      S_HDR_ERR: if (accept) begin
                   state_d = S_LD_T;
                   cnt_d   = '0;
                 end
      S_LD_T, S_LD_A, S_LD_B, S_LD_X0, S_LD_U0:
                 if (accept) begin
                   if (last_elem) begin
                     cnt_d = '0;
                     case (state_q)
                       S_LD_T:  state_d = S_LD_A;
                       S_LD_A:  state_d = S_LD_B;
                       S_LD_B:  state_d = S_LD_X0;
                       S_LD_X0: state_d = S_LD_U0;
                       default: state_d = S_DONE;
                     endcase
                   end else begin
                     cnt_d = cnt_q + 12'd1;
                   end
                 end
      S_DONE:    state_d = S_IDLE;
      S_ERR:     if (start) state_d = S_HDR_N;
      default:   state_d = S_IDLE;
    endcase
  end

  // Write datapath: address/data hold their last value whenever no write is issued.
  always_comb begin
    wr1_d   = 1'b0;
    wr2_d   = 1'b0;
    wr3_d   = 1'b0;
    wr4_d   = 1'b0;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    addr3_d = addr3_q;
    addr4_d = addr4_q;
    data1_d = data1_q;
    data2_d = data2_q;
    data3_d = data3_q;
    data4_d = data4_q;
    if (accept) begin
      case (state_q)
        S_HDR_N:   if (!bad_n) begin
                     wr1_d = 1'b1; addr1_d = '0; data1_d = data_in;
                     wr4_d = 1'b1; addr4_d = '0; data4_d = data_in;
                   end
        S_HDR_M:   if (!bad_m) begin
                     wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(1); data1_d = data_in;
                   end
        S_HDR_H:   begin wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(17); data4_d = data_in; end
        S_HDR_ERR: begin wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(18); data4_d = data_in; end
        S_LD_T:    begin
                     wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(cnt_q + 12'd2); data1_d = data_in;
                     wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(cnt_q + 12'd1); data4_d = data_in;
                   end
        S_LD_A:    begin wr2_d = 1'b1; addr2_d = ADDRESS_WIDTH_2'(cnt_q); data2_d = data_in; end
        S_LD_B:    begin wr3_d = 1'b1; addr3_d = ADDRESS_WIDTH_3'(cnt_q); data3_d = data_in; end
        S_LD_X0:   begin wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(cnt_q + 12'd19); data4_d = data_in; end
        S_LD_U0:   begin wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(cnt_q + 12'd18); data1_d = data_in; end
        default:   ;
      endcase
    end
  end

  always_comb begin
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_HDR_N, S_HDR_M, S_HDR_K, S_HDR_H, S_HDR_ERR,
      S_LD_T, S_LD_A, S_LD_B, S_LD_X0, S_LD_U0: begin
        data_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign WR_signal_1  = wr1_q;
  assign WR_signal_2  = wr2_q;
  assign WR_signal_3  = wr3_q;
  assign WR_signal_4  = wr4_q;
  assign address_1    = addr1_q;
  assign address_2    = addr2_q;
  assign address_3    = addr3_q;
  assign address_4    = addr4_q;
  assign data_write_1 = data1_q;
  assign data_write_2 = data2_q;
  assign data_write_3 = data3_q;
  assign data_write_4 = data4_q;

endmodule

// File: tb/tb_ram_input_loader.sv
// Directed bench for ram_input_loader: shadow RAMs capture every write, then
// contents, write counts, done pulses and bubble behaviour are checked.
module tb_ram_input_loader;
  localparam logic [63:0] HV = 64'h3F50624DD2F1A9FC;
  localparam logic [63:0] EV = 64'h3EE4F8B588E368F1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, busy, done, error;
  logic [9:0]  address_1, address_4;
  logic [11:0] address_2, address_3;
  logic [63:0] data_write_1, data_write_2, data_write_3, data_write_4;
  logic        WR_signal_1, WR_signal_2, WR_signal_3, WR_signal_4;

  int total = 0;
  int bad = 0;
  int wc1, wc2, wc3, wc4, orphan, done_cnt;
  bit acc_prev = 1'b0;
  logic [63:0] mem1 [1024];
  logic [63:0] mem2 [4096];
  logic [63:0] mem3 [4096];
  logic [63:0] mem4 [1024];
  logic [63:0] stream [$];
  logic [63:0] bad_hdr [5][3];
  int          bad_len [5];
  int          snap;

  ram_input_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready),
    .address_1(address_1), .address_2(address_2),
    .address_3(address_3), .address_4(address_4),
    .data_write_1(data_write_1), .data_write_2(data_write_2),
    .data_write_3(data_write_3), .data_write_4(data_write_4),
    .WR_signal_1(WR_signal_1), .WR_signal_2(WR_signal_2),
    .WR_signal_3(WR_signal_3), .WR_signal_4(WR_signal_4),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs reflect the previous posedge; a write is legal only if a word was accepted there.
  always @(negedge clk) begin
    if (rst_n) begin
      if (WR_signal_1) begin mem1[address_1] = data_write_1; wc1++; end
      if (WR_signal_2) begin mem2[address_2] = data_write_2; wc2++; end
      if (WR_signal_3) begin mem3[address_3] = data_write_3; wc3++; end
      if (WR_signal_4) begin mem4[address_4] = data_write_4; wc4++; end
      if ((WR_signal_1 || WR_signal_2 || WR_signal_3 || WR_signal_4) && !acc_prev) orphan++;
      if (done) done_cnt++;
      acc_prev = data_valid && data_ready;
    end else begin
      acc_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 1024; i++) begin mem1[i] = '0; mem4[i] = '0; end
    for (int i = 0; i < 4096; i++) begin mem2[i] = '0; mem3[i] = '0; end
    wc1 = 0; wc2 = 0; wc3 = 0; wc4 = 0; orphan = 0; done_cnt = 0;
  endtask

  task automatic build(input int n, input int m, input int k, input int tb0,
                       input int ab, input int bb, input int xb, input int ub);
    stream.delete();
    stream.push_back(64'(n)); stream.push_back(64'(m)); stream.push_back(64'(k));
    stream.push_back(HV); stream.push_back(EV);
    for (int i = 0; i < k; i++)     stream.push_back(64'(tb0 + i));
    for (int i = 0; i < n * n; i++) stream.push_back(64'(ab + i));
    for (int i = 0; i < n * m; i++) stream.push_back(64'(bb + i));
    for (int i = 0; i < n; i++)     stream.push_back(64'(xb + i));
    for (int i = 0; i < m; i++)     stream.push_back(64'(ub + i));
  endtask

  task automatic send_word(input logic [63:0] w, input bit st);
    int guard = 0;
    bit ok = 1'b0;
    data_in = w;
    data_valid = 1'b1;
    start = st;
    while (!ok && guard < 20) begin
      @(negedge clk);
      ok = data_ready;
      tick();
      start = 1'b0;
      guard++;
    end
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
    data_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit toggle, input int start_idx);
    for (int i = first; i <= last; i++) begin
      send_word(stream[i], i == start_idx);
      if (toggle && i != last) tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [63:0] last_u0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_last_wr1"}, 64'(WR_signal_1), 64'd1);
    check({tag, "_last_data1"}, data_write_1, last_u0);
    tick();
    tick();
  endtask

  task automatic check_small(input string tag);
    check({tag, "_m1_0"}, mem1[0], 64'd2);
    check({tag, "_m1_1"}, mem1[1], 64'd1);
    check({tag, "_m1_2"}, mem1[2], 64'd5);
    check({tag, "_m1_3"}, mem1[3], 64'd6);
    check({tag, "_m1_18"}, mem1[18], 64'd40);
    for (int i = 0; i < 4; i++) check({tag, "_m2"}, mem2[i], 64'(10 + i));
    check({tag, "_m3_0"}, mem3[0], 64'd20);
    check({tag, "_m3_1"}, mem3[1], 64'd21);
    check({tag, "_m4_0"}, mem4[0], 64'd2);
    check({tag, "_m4_1"}, mem4[1], 64'd5);
    check({tag, "_m4_2"}, mem4[2], 64'd6);
    check({tag, "_m4_17"}, mem4[17], HV);
    check({tag, "_m4_18"}, mem4[18], EV);
    check({tag, "_m4_19"}, mem4[19], 64'd30);
    check({tag, "_m4_20"}, mem4[20], 64'd31);
    check({tag, "_wc1"}, 64'(wc1), 64'd5);
    check({tag, "_wc2"}, 64'(wc2), 64'd4);
    check({tag, "_wc3"}, 64'(wc3), 64'd2);
    check({tag, "_wc4"}, 64'(wc4), 64'd7);
    check({tag, "_orphan"}, 64'(orphan), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic small_load(input string tag, input bit toggle, input int start_idx);
    clear_log();
    pulse_start();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_err_clr"}, 64'(error), 64'd0);
    build(2, 1, 2, 5, 10, 20, 30, 40);
    send_range(0, stream.size() - 1, toggle, start_idx);
    check_done(tag, 64'd40);
    check_small(tag);
  endtask

  initial begin
    bad_hdr[0] = '{64'd0, 64'd0, 64'd0};     bad_len[0] = 1;
    bad_hdr[1] = '{64'd51, 64'd0, 64'd0};    bad_len[1] = 1;
    bad_hdr[2] = '{64'h102, 64'd0, 64'd0};   bad_len[2] = 1;
    bad_hdr[3] = '{64'd2, 64'd0, 64'd0};     bad_len[3] = 2;
    bad_hdr[4] = '{64'd2, 64'd1, 64'd17};    bad_len[4] = 3;
    clear_log();

    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(data_ready), 64'd0);
    check("rst_wr", 64'({WR_signal_1, WR_signal_2, WR_signal_3, WR_signal_4}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_done", 64'(done), 64'd0);
    check("idle_error", 64'(error), 64'd0);
    check("idle_addr1", 64'(address_1), 64'd0);

    small_load("base", 1'b0, -1);
    small_load("bubble", 1'b1, -1);
    small_load("start_in_b", 1'b0, 11);

    for (int c = 0; c < 5; c++) begin
      clear_log();
      pulse_start();
      check("hdr_err_cleared", 64'(error), 64'd0);
      for (int j = 0; j < bad_len[c]; j++) send_word(bad_hdr[c][j], 1'b0);
      tick();
      check("hdr_error", 64'(error), 64'd1);
      check("hdr_ready", 64'(data_ready), 64'd0);
      check("hdr_busy", 64'(busy), 64'd0);
      snap = wc1 + wc2 + wc3 + wc4;
      data_in = 64'd7;
      data_valid = 1'b1;
      repeat (4) tick();
      data_valid = 1'b0;
      check("hdr_no_writes", 64'(wc1 + wc2 + wc3 + wc4), 64'(snap));
      check("hdr_still_err", 64'(error), 64'd1);
    end
    small_load("recover", 1'b0, -1);

    clear_log();
    pulse_start();
    build(2, 1, 2, 5, 10, 20, 30, 40);
    send_range(0, 8, 1'b0, -1);
    data_in = 64'd99;
    data_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr", 64'({WR_signal_1, WR_signal_2, WR_signal_3, WR_signal_4}), 64'd0);
    check("arst_addr2", 64'(address_2), 64'd0);
    check("arst_data2", data_write_2, 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(data_ready), 64'd0);
    data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    small_load("after_rst", 1'b0, -1);

    clear_log();
    pulse_start();
    build(50, 50, 16, 1000, 10000, 20000, 30000, 40000);
    send_range(0, stream.size() - 1, 1'b0, -1);
    check_done("max", 64'd40049);
    check("max_wc1", 64'(wc1), 64'd68);
    check("max_wc2", 64'(wc2), 64'd2500);
    check("max_wc3", 64'(wc3), 64'd2500);
    check("max_wc4", 64'(wc4), 64'd69);
    check("max_a_last", mem2[2499], 64'd12499);
    check("max_b_last", mem3[2499], 64'd22499);
    check("max_x0_last", mem4[68], 64'd30049);
    check("max_u0_last", mem1[67], 64'd40049);
    check("max_t_last1", mem1[17], 64'd1015);
    check("max_t_last4", mem4[16], 64'd1015);
    check("max_n4", mem4[0], 64'd50);
    check("max_m1", mem1[1], 64'd50);
    check("max_orphan", 64'(orphan), 64'd0);
    check("max_done_cnt", 64'(done_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
